// File: rtl/cnt_hms_chain_pkg.sv
// Shared constants and helpers for the hours/minutes/seconds counter chain.
package cnt_pkg;

    localparam int SEC_MOD_DEF = 60;
    localparam int MIN_MOD_DEF = 60;
    localparam int HR_MOD_DEF  = 24;

    localparam logic [31:0] DIV_1S_50M = 32'd50000000;

    // Out-of-range preload values clamp to the top of the stage's range.
    function automatic logic [31:0] sat_load(input logic [31:0] value, input logic [31:0] mod);
        logic [31:0] result;
        if (value >= mod) begin
            result = mod - 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/cnt_hms_chain_stage.sv
// One modulus stage of the chain: wraps up or down and flags carry/borrow-out.
module cnt_stage
    import cnt_pkg::*;
#(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         co
);

    localparam logic [W-1:0] TOP  = W'(MOD - 1);
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] q_r;
    logic         at_edge_s;

    // Stage sits at the value that wraps in the current direction.
    always_comb begin
        at_edge_s = 1'b0;
        if (up_dn) begin
            at_edge_s = (q_r == TOP);
        end else begin
            at_edge_s = (q_r == ZERO);
        end
        co = inc && at_edge_s;
    end

    // Stage value register: reset, then preload, then count.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= ZERO;
        end else if (load) begin
            q_r <= W'(sat_load(32'(load_val), 32'(MOD)));
        end else if (inc) begin
            if (up_dn) begin
                q_r <= at_edge_s ? ZERO : (q_r + ONE);
            end else begin
                q_r <= at_edge_s ? TOP : (q_r - ONE);
            end
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/cnt_hms_chain.sv
// Prescaled seconds/minutes/hours counter with up/down, pause, preload and
// tick/rollover pulses for the display path.
module cnt_hms_chain
    import cnt_pkg::*;
#(
    parameter int SEC_MOD = SEC_MOD_DEF,
    parameter int MIN_MOD = MIN_MOD_DEF,
    parameter int HR_MOD  = HR_MOD_DEF,
    parameter int SW      = 6,
    parameter int HW      = 5,
    parameter int DIVW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIVW-1:0] num,
    input  logic            en,
    input  logic            up_dn,
    input  logic            load,
    input  logic [SW-1:0]   load_sec,
    input  logic [SW-1:0]   load_min,
    input  logic [HW-1:0]   load_hr,
    output logic [SW-1:0]   sec,
    output logic [SW-1:0]   min,
    output logic [HW-1:0]   hr,
    output logic            tick,
    output logic            rollover
);

    localparam logic [DIVW-1:0] DIV_ZERO = {DIVW{1'b0}};
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
    localparam logic [DIVW-1:0] DIV_TWO  = DIVW'(2);

    logic [DIVW-1:0] div_cnt_r;
    logic [DIVW-1:0] period_last_s;
    logic            tick_event_s;
    logic            tick_r;
    logic            rollover_r;
    logic            sec_co_s;
    logic            min_co_s;
    logic            hr_co_s;

    // Terminal prescaler count; num of 0 or 1 collapses to a tick every cycle.
    // The >= compare lets a lowered num take effect on the next enabled edge.
    always_comb begin
        period_last_s = DIV_ZERO;
        if (num >= DIV_TWO) begin
            period_last_s = num - DIV_ONE;
        end else begin
            period_last_s = DIV_ZERO;
        end
        tick_event_s = en && (div_cnt_r >= period_last_s);
    end

    // Prescaler: cleared by reset or preload, frozen while paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= DIV_ZERO;
        end else if (load) begin
            div_cnt_r <= DIV_ZERO;
        end else if (tick_event_s) begin
            div_cnt_r <= DIV_ZERO;
        end else if (en) begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    // Pulse registers; a preload suppresses any coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r     <= 1'b0;
            rollover_r <= 1'b0;
        end else if (load) begin
            tick_r     <= 1'b0;
            rollover_r <= 1'b0;
        end else begin
            tick_r     <= tick_event_s;
            rollover_r <= hr_co_s;
        end
    end

    cnt_stage #(.MOD(SEC_MOD), .W(SW)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (tick_event_s),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_sec),
        .q        (sec),
        .co       (sec_co_s)
    );

    cnt_stage #(.MOD(MIN_MOD), .W(SW)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_co_s),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_min),
        .q        (min),
        .co       (min_co_s)
    );

    // Hours carry-out means every stage wrapped on this tick.
    cnt_stage #(.MOD(HR_MOD), .W(HW)) u_hr (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_co_s),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_hr),
        .q        (hr),
        .co       (hr_co_s)
    );

    assign tick     = tick_r;
    assign rollover = rollover_r;

endmodule

// File: tb/tb_cnt_hms_chain.sv
// Self-checking bench: total-seconds reference model compared every cycle,
// plus directed hand-computed checkpoints.
module tb_cnt_hms_chain;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;
    localparam int SW      = 6;
    localparam int HW      = 5;
    localparam int DIVW    = 32;
    localparam int TOTAL   = SEC_MOD * MIN_MOD * HR_MOD;

    logic            clk = 1'b0;
    logic            rst;
    logic [DIVW-1:0] num;
    logic            en;
    logic            up_dn;
    logic            load;
    logic [SW-1:0]   load_sec;
    logic [SW-1:0]   load_min;
    logic [HW-1:0]   load_hr;
    logic [SW-1:0]   sec;
    logic [SW-1:0]   min;
    logic [HW-1:0]   hr;
    logic            tick;
    logic            rollover;

    int errors = 0;
    int checks = 0;

    cnt_hms_chain #(
        .SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD), .HR_MOD(HR_MOD),
        .SW(SW), .HW(HW), .DIVW(DIVW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .num      (num),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_sec (load_sec),
        .load_min (load_min),
        .load_hr  (load_hr),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .tick     (tick),
        .rollover (rollover)
    );

    always #5 clk = ~clk;

    // Reference model: time as total seconds since 00:00:00.
    int     m_t     = 0;
    longint m_div   = 0;
    bit     m_tick  = 1'b0;
    bit     m_roll  = 1'b0;
    bit     m_valid = 1'b0;

    function automatic int clamp(input int v, input int mod);
        return (v >= mod) ? mod - 1 : v;
    endfunction

    function automatic longint period(input logic [DIVW-1:0] n);
        longint p;
        p = longint'({32'd0, n});
        return (p >= 2) ? p : 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t <= 0; m_div <= 0; m_tick <= 1'b0; m_roll <= 1'b0; m_valid <= 1'b1;
        end else if (load) begin
            m_t <= (clamp(int'(load_hr), HR_MOD) * MIN_MOD + clamp(int'(load_min), MIN_MOD)) * SEC_MOD
                   + clamp(int'(load_sec), SEC_MOD);
            m_div <= 0; m_tick <= 1'b0; m_roll <= 1'b0;
        end else if (en && m_div >= period(num) - 1) begin
            m_div  <= 0;
            m_tick <= 1'b1;
            m_t    <= up_dn ? (m_t + 1) % TOTAL : (m_t + TOTAL - 1) % TOTAL;
            m_roll <= up_dn ? (m_t == TOTAL - 1) : (m_t == 0);
        end else begin
            if (en) m_div <= m_div + 1;
            m_tick <= 1'b0;
            m_roll <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [SW-1:0] e_sec;
        logic [SW-1:0] e_min;
        logic [HW-1:0] e_hr;
        if (m_valid) begin
            e_sec = SW'(m_t % SEC_MOD);
            e_min = SW'((m_t / SEC_MOD) % MIN_MOD);
            e_hr  = HW'(m_t / (SEC_MOD * MIN_MOD));
            checks++;
            if (sec !== e_sec || min !== e_min || hr !== e_hr || tick !== m_tick || rollover !== m_roll) begin
                errors++;
                $display("FAIL model t=%0t: got %0d:%0d:%0d tick=%b roll=%b, want %0d:%0d:%0d tick=%b roll=%b",
                         $time, hr, min, sec, tick, rollover, e_hr, e_min, e_sec, m_tick, m_roll);
            end
        end
    end

    task automatic check_hms(input string name, input int eh, input int em, input int es,
                             input bit et, input bit er);
        checks++;
        if (hr !== HW'(eh) || min !== SW'(em) || sec !== SW'(es) || tick !== et || rollover !== er) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d tick=%b roll=%b, want %0d:%0d:%0d tick=%b roll=%b",
                     name, hr, min, sec, tick, rollover, eh, em, es, et, er);
        end
    endtask

    task automatic do_load(input int s, input int m, input int h);
        load_sec = SW'(s); load_min = SW'(m); load_hr = HW'(h);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; num = 32'd4;
        load_sec = 6'd0; load_min = 6'd0; load_hr = 5'd0;
        @(negedge clk);
        check_hms("reset", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; en = 1'b1;

        // First tick on the 4th edge after release, then every 4.
        repeat (3) @(negedge clk);
        check_hms("pre_tick", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_hms("latency", 0, 0, 1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_hms("second_tick", 0, 0, 2, 1'b1, 1'b0);

        // Up cascade through full wrap.
        num = 32'd2;
        do_load(58, 59, 23);
        check_hms("load_up", 23, 59, 58, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_hms("up_59", 23, 59, 59, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_hms("up_wrap", 0, 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        check_hms("up_wrap_end", 0, 0, 0, 1'b0, 1'b0);

        // Minute carry into hours.
        num = 32'd1;
        do_load(59, 59, 0);
        @(negedge clk);
        check_hms("min_carry", 1, 0, 0, 1'b1, 1'b0);

        // Down borrow.
        up_dn = 1'b0;
        do_load(0, 0, 1);
        @(negedge clk);
        check_hms("down_borrow", 0, 59, 59, 1'b1, 1'b0);
        do_load(0, 0, 0);
        @(negedge clk);
        check_hms("down_wrap", 23, 59, 59, 1'b1, 1'b1);

        // Pause at div_cnt=3 for 10 cycles, then resume.
        up_dn = 1'b1; num = 32'd5;
        do_load(0, 0, 0);
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check_hms("paused", 0, 0, 0, 1'b0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        check_hms("resume_1", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_hms("resume_2", 0, 0, 1, 1'b1, 1'b0);

        // Saturating preload, load beating a tick, reset beating load.
        do_load(63, 60, 30);
        check_hms("load_sat", 23, 59, 59, 1'b0, 1'b0);
        num = 32'd3;
        repeat (2) @(negedge clk);
        do_load(30, 20, 10);
        check_hms("load_on_tick", 10, 20, 30, 1'b0, 1'b0);
        rst = 1'b1;
        do_load(5, 5, 5);
        rst = 1'b0;
        check_hms("rst_over_load", 0, 0, 0, 1'b0, 1'b0);

        // num of 0 and 1 tick every cycle.
        num = 32'd0;
        repeat (3) @(negedge clk);
        check_hms("num0", 0, 0, 3, 1'b1, 1'b0);
        num = 32'd1;
        repeat (3) @(negedge clk);
        check_hms("num1", 0, 0, 6, 1'b1, 1'b0);

        // Lowering num below the running count forces an immediate tick.
        num = 32'd100;
        do_load(0, 0, 0);
        repeat (50) @(negedge clk);
        check_hms("num100_mid", 0, 0, 0, 1'b0, 1'b0);
        num = 32'd3;
        @(negedge clk);
        check_hms("num_lowered", 0, 0, 1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_hms("num3_period", 0, 0, 2, 1'b1, 1'b0);

        // Mixed sweep around the wrap point: direction, pause, period and loads vary.
        do_load(50, 59, 23);
        for (int i = 0; i < 240; i++) begin
            en    = (i % 7) != 6;
            up_dn = ((i / 40) % 2) == 0;
            num   = 32'(i % 4);
            if (i % 53 == 52) begin
                load_sec = SW'(i); load_min = SW'(i * 3); load_hr = HW'(i);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
